// File: rtl/mem_port_arbiter_if.sv
// Bundles the IF-stage, MEM-stage and memory-side signals of the unified memory port.
// Latency: none (wires only).
// Backpressure: requesters hold *_req until the matching *_valid pulse; *_stall mirrors the wait.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // instruction fetch requester
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              if_stall;

  // data memory requester
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_valid;
  logic              dm_stall;

  // shared single-port memory
  logic              m_en;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;

  // arbiter view
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, m_rdata,
    output if_rdata, if_valid, if_stall, dm_rdata, dm_valid, dm_stall,
           m_en, m_we, m_addr, m_wdata
  );

  // pipeline + memory view
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, m_rdata,
    input  if_rdata, if_valid, if_stall, dm_rdata, dm_valid, dm_stall,
           m_en, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises IF reads and MEM reads/writes onto one fixed-latency single-port memory.
// Latency: issue in cycle T, valid pulse in T+MEM_LAT+1; one access occupies MEM_LAT+2 cycles.
// Backpressure: losing/waiting requester sees *_stall=1 until its *_valid; DM wins unless IF is starved.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  mem_port_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam int ST_W  = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
  typedef enum logic {OWN_IF, OWN_DM} owner_t;

  state_t            state;
  owner_t            owner;
  logic [CNT_W-1:0]  cnt;
  logic [ST_W-1:0]   starve_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;
  logic              if_valid_q;
  logic              dm_valid_q;

  logic              starved;
  logic              grant_if;
  logic              grant_dm;
  logic              issue;
  logic [ADDR_W-1:0] issue_addr;
  logic [DATA_W-1:0] issue_wdata;
  logic              issue_we;

  // Grant selection: DM has priority unless IF has waited through STARVE_MAX DM grants.
  // Reset gates the issue so the memory never sees a strobe while rst is low.
  always_comb begin
    starved     = (starve_cnt == ST_W'(STARVE_MAX));
    grant_if    = bus.if_req & (~bus.dm_req | starved);
    grant_dm    = bus.dm_req & ~grant_if;
    issue       = rst & (state == S_IDLE) & (bus.if_req | bus.dm_req);
    issue_addr  = grant_dm ? bus.dm_addr  : bus.if_addr;
    issue_wdata = grant_dm ? bus.dm_wdata : wdata_q;
    issue_we    = grant_dm & bus.dm_we;
  end

  // Memory-side drive: live grant values in the issue cycle, latched values afterwards.
  always_comb begin
    bus.m_en    = issue;
    bus.m_we    = issue & issue_we;
    bus.m_addr  = issue ? issue_addr  : addr_q;
    bus.m_wdata = issue ? issue_wdata : wdata_q;
  end

  // Requester-side outputs; stalls follow the live request so a dropped request never stalls.
  always_comb begin
    bus.if_rdata = if_rdata_q;
    bus.if_valid = if_valid_q;
    bus.if_stall = bus.if_req & ~if_valid_q;
    bus.dm_rdata = dm_rdata_q;
    bus.dm_valid = dm_valid_q;
    bus.dm_stall = bus.dm_req & ~dm_valid_q;
  end

  // Access FSM: IDLE issues, WAIT counts down memory latency and captures read data, DONE pulses valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      owner      <= OWN_IF;
      cnt        <= '0;
      starve_cnt <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
    end else begin
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (issue) begin
            owner   <= grant_dm ? OWN_DM : OWN_IF;
            addr_q  <= issue_addr;
            wdata_q <= issue_wdata;
            we_q    <= issue_we;
            cnt     <= CNT_W'(MEM_LAT - 1);
            state   <= S_WAIT;
            if (grant_if) begin
              starve_cnt <= '0;
            end else if (bus.if_req && !starved) begin
              starve_cnt <= starve_cnt + 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            if (owner == OWN_IF) begin
              if_rdata_q <= bus.m_rdata;
              if_valid_q <= 1'b1;
            end else begin
              // stores complete without disturbing the last load value
              if (!we_q) begin
                dm_rdata_q <= bus.m_rdata;
              end
              dm_valid_q <= 1'b1;
            end
            state <= S_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural fixed-latency memory.
// Latency: memory returns read data MEM_LAT cycles after m_en, garbage otherwise.
// Backpressure: requests are held until the bench observes the matching valid pulse.
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;

  logic clk;
  logic rst;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .MEM_LAT   (MEM_LAT),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural memory: preset contents unless written, read pipeline MEM_LAT deep
  logic [DATA_W-1:0] mem_q  [256];
  bit                mem_wr [256];
  logic [DATA_W-1:0] pipe_d [MEM_LAT];
  bit                pipe_v [MEM_LAT];

  function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return {16'hA5A5, a[15:0]};
  endfunction

  function automatic logic [DATA_W-1:0] mem_rd(input logic [ADDR_W-1:0] a);
    return mem_wr[a[9:2]] ? mem_q[a[9:2]] : init_val(a);
  endfunction

  // memory model: write on the strobe edge, read data travels MEM_LAT stages
  always @(posedge clk) begin
    if (bus.m_en && bus.m_we) begin
      mem_q[bus.m_addr[9:2]]  <= bus.m_wdata;
      mem_wr[bus.m_addr[9:2]] <= 1'b1;
    end
    pipe_v[0] <= bus.m_en && !bus.m_we;
    pipe_d[0] <= mem_rd(bus.m_addr);
    for (int i = 1; i < MEM_LAT; i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_d[i] <= pipe_d[i-1];
    end
  end

  assign bus.m_rdata = pipe_v[MEM_LAT-1] ? pipe_d[MEM_LAT-1] : 32'hBAD0BAD0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic cyc_start();
    @(posedge clk);
    #1;
  endtask

  task automatic smp(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst          = 1'b0;
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.dm_req   = 1'b0;
    bus.dm_we    = 1'b0;
    bus.dm_addr  = '0;
    bus.dm_wdata = '0;

    // reset state
    smp(2);
    check_val("rst_if_valid", bus.if_valid, 0);
    check_val("rst_dm_valid", bus.dm_valid, 0);
    check_val("rst_if_rdata", bus.if_rdata, 0);
    check_val("rst_dm_rdata", bus.dm_rdata, 0);
    check_val("rst_if_stall", bus.if_stall, 0);
    check_val("rst_m_en", bus.m_en, 0);
    bus.dm_req = 1'b1;
    bus.dm_we  = 1'b1;
    #1;
    check_val("rst_req_m_en", bus.m_en, 0);
    check_val("rst_req_m_we", bus.m_we, 0);
    check_val("rst_req_dm_stall", bus.dm_stall, 1);
    bus.dm_req = 1'b0;
    bus.dm_we  = 1'b0;
    cyc_start();
    rst = 1'b1;
    smp(1);
    check_val("idle_m_en", bus.m_en, 0);

    // 1: single IF read of 0x10
    cyc_start();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h10;
    smp(1);
    check_val("t1_c0_m_en", bus.m_en, 1);
    check_val("t1_c0_m_addr", bus.m_addr, 32'h10);
    check_val("t1_c0_m_we", bus.m_we, 0);
    check_val("t1_c0_if_stall", bus.if_stall, 1);
    smp(1);
    check_val("t1_c1_m_en", bus.m_en, 0);
    check_val("t1_c1_if_stall", bus.if_stall, 1);
    smp(1);
    check_val("t1_c2_if_valid", bus.if_valid, 0);
    check_val("t1_c2_if_stall", bus.if_stall, 1);
    smp(1);
    check_val("t1_c3_if_valid", bus.if_valid, 1);
    check_val("t1_c3_if_rdata", bus.if_rdata, 32'hDEADBEEF);
    check_val("t1_c3_if_stall", bus.if_stall, 0);
    check_val("t1_c3_m_en", bus.m_en, 0);
    cyc_start();
    bus.if_req = 1'b0;
    smp(1);
    check_val("t1_c4_if_valid", bus.if_valid, 0);
    check_val("t1_c4_m_en", bus.m_en, 0);

    // 2: simultaneous requests, DM first
    cyc_start();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h20;
    bus.dm_req  = 1'b1;
    bus.dm_we   = 1'b0;
    bus.dm_addr = 32'h80;
    smp(1);
    check_val("t2_c0_m_en", bus.m_en, 1);
    check_val("t2_c0_m_addr", bus.m_addr, 32'h80);
    smp(3);
    check_val("t2_c3_dm_valid", bus.dm_valid, 1);
    check_val("t2_c3_dm_rdata", bus.dm_rdata, 32'hA5A50080);
    check_val("t2_c3_if_valid", bus.if_valid, 0);
    check_val("t2_c3_if_stall", bus.if_stall, 1);
    cyc_start();
    bus.dm_req = 1'b0;
    smp(1);
    check_val("t2_c4_m_en", bus.m_en, 1);
    check_val("t2_c4_m_addr", bus.m_addr, 32'h20);
    smp(3);
    check_val("t2_c7_if_valid", bus.if_valid, 1);
    check_val("t2_c7_if_rdata", bus.if_rdata, 32'hA5A50020);
    check_val("t2_c7_dm_valid", bus.dm_valid, 0);
    cyc_start();
    bus.if_req = 1'b0;

    // 3: write 0x1234 to 0x40, then read it back
    bus.dm_req   = 1'b1;
    bus.dm_we    = 1'b1;
    bus.dm_addr  = 32'h40;
    bus.dm_wdata = 32'h1234;
    smp(1);
    check_val("t3_c0_m_en", bus.m_en, 1);
    check_val("t3_c0_m_we", bus.m_we, 1);
    check_val("t3_c0_m_addr", bus.m_addr, 32'h40);
    check_val("t3_c0_m_wdata", bus.m_wdata, 32'h1234);
    smp(1);
    check_val("t3_c1_m_we", bus.m_we, 0);
    smp(2);
    check_val("t3_c3_dm_valid", bus.dm_valid, 1);
    check_val("t3_c3_dm_rdata_kept", bus.dm_rdata, 32'hA5A50080);
    cyc_start();
    bus.dm_we = 1'b0;
    smp(1);
    check_val("t3_c4_m_en", bus.m_en, 1);
    check_val("t3_c4_m_we", bus.m_we, 0);
    smp(3);
    check_val("t3_c7_dm_valid", bus.dm_valid, 1);
    check_val("t3_c7_dm_rdata", bus.dm_rdata, 32'h1234);
    cyc_start();
    bus.dm_req = 1'b0;
    smp(1);

    // 4: continuous contention, IF forced after STARVE_MAX DM grants
    cyc_start();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h30;
    bus.dm_req  = 1'b1;
    bus.dm_we   = 1'b0;
    bus.dm_addr = 32'h90;
    smp(1);
    for (int g = 1; g <= 6; g++) begin
      if (g > 1) smp(1);
      k = 0;
      while (!bus.m_en && k < 12) begin
        smp(1);
        k++;
      end
      check_val($sformatf("t4_g%0d_m_en", g), bus.m_en, 1);
      check_val($sformatf("t4_g%0d_addr", g), bus.m_addr, (g == 5) ? 32'h30 : 32'h90);
      if (g > 1) check_val($sformatf("t4_g%0d_gap", g), k, MEM_LAT + 1);
    end
    smp(3);
    check_val("t4_last_dm_valid", bus.dm_valid, 1);
    cyc_start();
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    smp(1);

    // 5: reset in cycle 1 of an IF read
    cyc_start();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h10;
    smp(1);
    check_val("t5_c0_m_en", bus.m_en, 1);
    cyc_start();
    rst = 1'b0;
    #1;
    check_val("t5_rst_if_valid", bus.if_valid, 0);
    check_val("t5_rst_dm_valid", bus.dm_valid, 0);
    check_val("t5_rst_m_en", bus.m_en, 0);
    check_val("t5_rst_if_rdata", bus.if_rdata, 0);
    check_val("t5_rst_dm_rdata", bus.dm_rdata, 0);
    check_val("t5_rst_if_stall", bus.if_stall, 1);
    smp(1);
    check_val("t5_c1_m_en", bus.m_en, 0);
    smp(1);
    check_val("t5_c2_if_valid", bus.if_valid, 0);
    cyc_start();
    rst = 1'b1;
    smp(1);
    check_val("t5_c3_if_valid", bus.if_valid, 0);
    check_val("t5_c3_m_en", bus.m_en, 1);
    check_val("t5_c3_m_addr", bus.m_addr, 32'h10);
    smp(1);
    check_val("t5_c4_if_valid", bus.if_valid, 0);
    smp(1);
    check_val("t5_c5_if_valid", bus.if_valid, 0);
    smp(1);
    check_val("t5_c6_if_valid", bus.if_valid, 1);
    check_val("t5_c6_if_rdata", bus.if_rdata, 32'hDEADBEEF);
    cyc_start();
    bus.if_req = 1'b0;
    smp(1);

    // 6: DM read request dropped after issue
    cyc_start();
    bus.dm_req  = 1'b1;
    bus.dm_we   = 1'b0;
    bus.dm_addr = 32'h84;
    smp(1);
    check_val("t6_c0_m_en", bus.m_en, 1);
    check_val("t6_c0_dm_stall", bus.dm_stall, 1);
    cyc_start();
    bus.dm_req = 1'b0;
    smp(1);
    check_val("t6_c1_dm_stall", bus.dm_stall, 0);
    smp(2);
    check_val("t6_c3_dm_valid", bus.dm_valid, 1);
    check_val("t6_c3_dm_rdata", bus.dm_rdata, 32'hA5A50084);
    check_val("t6_c3_dm_stall", bus.dm_stall, 0);
    smp(1);
    check_val("t6_c4_m_en", bus.m_en, 0);
    check_val("t6_c4_dm_valid", bus.dm_valid, 0);
    smp(1);
    check_val("t6_c5_m_en", bus.m_en, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
